// File: rtl/cache_miss_arbiter_pkg.sv
// Shared definitions for the cache miss arbiter.
// Holds the controller state encoding and a small index helper that the
// top level and the arbiter both use.
package cache_miss_arbiter_pkg;

  // Controller states. The encoding is fixed so that state values can be
  // recognised on a debug bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Index width for a port count. The minimum is one bit so that a
  // single-port build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_miss_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational request arbiter.
// Ports:
//   req         in   NUM_PORTS  request vector
//   rr_ptr      in   IDX_W      round-robin start index (ignored when FIXED_PRIO=1)
//   grant_oh    out  NUM_PORTS  one-hot grant, all zero when nobody requests
//   grant_idx   out  IDX_W      binary index of the granted port
//   grant_valid out  1          at least one request is present
module rr_arbiter
  import cache_miss_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int FIXED_PRIO = 0,
  parameter int IDX_W      = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  // cand_idx[k] is the port examined at search offset k. Offset 0 has the
  // highest priority: the pointer position under round-robin, port 0 under
  // fixed priority.
  logic [IDX_W-1:0] cand_idx [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand_idx[gi] = (FIXED_PRIO != 0) ? IDX_W'(gi)
                                            : IDX_W'((int'(rr_ptr) + gi) % NUM_PORTS);
  end

  // Scan from the lowest-priority offset upwards so the last hit, which is
  // the highest-priority requester, wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant_idx   = cand_idx[k];
        grant_valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
    assign grant_oh[gi] = grant_valid && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/cache_miss_arbiter.sv
// cache_miss_arbiter: serialises cache misses from NUM_PORTS caches onto
// one memory port. It writes the dirty victim back first when required,
// then fetches the missing line and returns it with a one-cycle fill strobe.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   miss_req/miss_dirty         per-port request level and victim-dirty flag
//   miss_addr/evict_addr        packed per-port line addresses (ADDR_W each)
//   evict_data                  packed per-port victim data (LINE_W each)
//   fill_data, fill_we, done    returned line, one-hot strobe, one-hot completion
//   busy                        a transaction is in progress
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata/mem_rdy  memory port
module cache_miss_arbiter
  import cache_miss_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 16,
  parameter int LINE_W     = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        miss_req,
  input  logic [NUM_PORTS-1:0]        miss_dirty,
  input  logic [NUM_PORTS*ADDR_W-1:0] miss_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0] evict_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] evict_data,
  output logic [LINE_W-1:0]           fill_data,
  output logic [NUM_PORTS-1:0]        fill_we,
  output logic [NUM_PORTS-1:0]        done,
  output logic                        busy,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_rdy
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  state_t              state_reg;
  logic [IDX_W-1:0]    grant_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [ADDR_W-1:0]   miss_addr_reg;
  logic [ADDR_W-1:0]   evict_addr_reg;
  logic [LINE_W-1:0]   evict_data_reg;
  logic [LINE_W-1:0]   fill_data_reg;

  logic [NUM_PORTS-1:0] arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [IDX_W-1:0]     rr_ptr_next;

  rr_arbiter #(
    .NUM_PORTS  (NUM_PORTS),
    .FIXED_PRIO (FIXED_PRIO),
    .IDX_W      (IDX_W)
  ) u_arb (
    .req         (miss_req),
    .rr_ptr      (rr_ptr_reg),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // The pointer moves to the port just after the winner, wrapping without
  // relying on NUM_PORTS being a power of two.
  assign rr_ptr_next = (arb_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      miss_addr_reg  <= '0;
      evict_addr_reg <= '0;
      evict_data_reg <= '0;
      fill_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            // Everything the transaction needs is captured here; port
            // inputs are not looked at again until the next grant.
            grant_reg      <= arb_idx;
            miss_addr_reg  <= miss_addr[arb_idx*ADDR_W +: ADDR_W];
            evict_addr_reg <= evict_addr[arb_idx*ADDR_W +: ADDR_W];
            evict_data_reg <= evict_data[arb_idx*LINE_W +: LINE_W];
            state_reg      <= (|(miss_dirty & arb_oh)) ? ST_EVICT : ST_FILL;
            if (FIXED_PRIO == 0) begin
              rr_ptr_reg <= rr_ptr_next;
            end
          end
        end
        ST_EVICT: begin
          if (mem_rdy) begin
            state_reg <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_rdy) begin
            fill_data_reg <= mem_rdata;
            state_reg     <= ST_RESP;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs decode the state register only, so a request is
  // never driven in IDLE/RESP and read/write are mutually exclusive.
  always_comb begin
    mem_we    = (state_reg == ST_EVICT);
    mem_re    = (state_reg == ST_FILL);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_reg == ST_EVICT) begin
      mem_addr  = evict_addr_reg;
      mem_wdata = evict_data_reg;
    end else if (state_reg == ST_FILL) begin
      mem_addr  = miss_addr_reg;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign fill_data = fill_data_reg;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
    assign done[gi]    = (state_reg == ST_RESP) && (grant_reg == IDX_W'(gi));
    assign fill_we[gi] = (state_reg == ST_RESP) && (grant_reg == IDX_W'(gi));
  end

endmodule
